// File: rtl/truth_table_sweeper_if.sv
// Start/done handshake plus function-under-test wiring between a controller
// (master) and the truth-table sweeper (slave).
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
);
  localparam int W = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [W-1:0]    expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [W-1:0]    truth;
  logic            pass;
  logic [N_IN-1:0] fail_idx;

  modport master (
    output start, abort, expected, dut_out,
    input  dut_in, busy, done, truth, pass, fail_idx
  );

  modport slave (
    input  start, abort, expected, dut_out,
    output dut_in, busy, done, truth, pass, fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a combinational function through all 2**N_IN input vectors, captures
// its output per vector after SETTLE extra cycles and grades it against a table.
module truth_table_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  truth_table_sweeper_if.slave bus
);
  localparam int              W        = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(W - 1);
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  localparam logic [3:0]      CNT_INIT = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [W-1:0]    truth_q, truth_d;
  logic [W-1:0]    exp_q, exp_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;

  logic [W-1:0]    mismatch;
  logic            pass_calc;
  logic [N_IN-1:0] fail_calc;

  assign mismatch  = truth_q ^ exp_q;
  assign pass_calc = (mismatch == '0);

  // Scan from the top down so the lowest mismatching index wins.
  always_comb begin
    fail_calc = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mismatch[i]) fail_calc = N_IN'(i);
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in_q;
    truth_d    = truth_q;
    exp_d      = exp_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          exp_d      = bus.expected;
          truth_d    = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          idx_d      = '0;
          dut_in_d   = '0;
          cnt_d      = CNT_INIT;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Abort wins over a sample falling on the same edge.
        if (bus.abort) begin
          state_d  = ST_IDLE;
          pass_d   = 1'b0;
          dut_in_d = '0;
          idx_d    = '0;
          cnt_d    = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          truth_d[idx_q] = bus.dut_out;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_q + IDX_ONE;
            dut_in_d = idx_q + IDX_ONE;
            cnt_d    = CNT_INIT;
          end
        end
      end

      ST_DONE: begin
        pass_d     = pass_calc;
        fail_idx_d = fail_calc;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      dut_in_q   <= '0;
      truth_q    <= '0;
      exp_q      <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dut_in_q   <= dut_in_d;
      truth_q    <= truth_d;
      exp_q      <= exp_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // The verdict is live during the done pulse and held from its register after.
  assign bus.dut_in   = dut_in_q;
  assign bus.busy     = (state_q == ST_WAIT);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.truth    = truth_q;
  assign bus.pass     = (state_q == ST_DONE) ? pass_calc : pass_q;
  assign bus.fail_idx = (state_q == ST_DONE) ? fail_calc : fail_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: 2-input gates at SETTLE=1 and an
// XOR3 at SETTLE=0, with abort, mid-sweep reset and start-handshake cases.
module tb_truth_table_sweeper;
  localparam logic [1:0] F_AND  = 2'd0;
  localparam logic [1:0] F_OR   = 2'd1;
  localparam logic [1:0] F_NAND = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] func_sel;
  int         checks   = 0;
  int         failures = 0;

  truth_table_sweeper_if #(.N_IN(2)) bus0 ();
  truth_table_sweeper_if #(.N_IN(3)) bus1 ();

  assign bus0.dut_out = (func_sel == F_OR)   ? (bus0.dut_in[1] | bus0.dut_in[0]) :
                        (func_sel == F_NAND) ? ~(bus0.dut_in[1] & bus0.dut_in[0]) :
                                               (bus0.dut_in[1] & bus0.dut_in[0]);
  assign bus1.dut_out = ^bus1.dut_in;

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a sweep on bus0 and follow it cycle by cycle to the done pulse.
  task automatic run_sweep0(input string name, input logic [3:0] exp_tt);
    bus0.expected = exp_tt;
    bus0.start    = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("%s_busy_c%0d", name, c), bus0.busy, 1);
      chk($sformatf("%s_done_c%0d", name, c), bus0.done, 0);
      chk($sformatf("%s_dut_in_c%0d", name, c), bus0.dut_in, (c - 1) / 2);
      tick();
    end
    chk({name, "_done_c9"}, bus0.done, 1);
    chk({name, "_busy_c9"}, bus0.busy, 0);
  endtask

  task automatic wait_done0(input int budget, output int cycles);
    cycles = 0;
    while (!bus0.done && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("wait_done0_reached", bus0.done, 1);
  endtask

  initial begin
    int n_done;
    int first_done;
    int second_done;
    int cyc;

    reset         = 1'b1;
    func_sel      = F_AND;
    bus0.start    = 1'b0;
    bus0.abort    = 1'b0;
    bus0.expected = '0;
    bus1.start    = 1'b0;
    bus1.abort    = 1'b0;
    bus1.expected = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_truth", bus0.truth, 0);
    chk("rst_pass", bus0.pass, 0);
    chk("rst_fail_idx", bus0.fail_idx, 0);
    chk("rst_dut_in", bus0.dut_in, 0);
    chk("rst_truth3", bus1.truth, 0);

    // AND2 graded against its own table.
    func_sel = F_AND;
    run_sweep0("and2", 4'b1000);
    chk("and2_truth", bus0.truth, 4'b1000);
    chk("and2_pass", bus0.pass, 1);
    chk("and2_fail_idx", bus0.fail_idx, 0);
    tick();
    chk("and2_done_drop", bus0.done, 0);
    chk("and2_pass_held", bus0.pass, 1);
    chk("and2_truth_held", bus0.truth, 4'b1000);

    // OR2 wired as x|y against an x|~y table: mismatches at 0 and 2.
    func_sel = F_OR;
    run_sweep0("or2", 4'b1011);
    chk("or2_truth", bus0.truth, 4'b1110);
    chk("or2_pass", bus0.pass, 0);
    chk("or2_fail_idx", bus0.fail_idx, 0);
    tick();
    chk("or2_pass_held", bus0.pass, 0);

    // Single mismatch at vector 2.
    run_sweep0("or2b", 4'b1010);
    chk("or2b_pass", bus0.pass, 0);
    chk("or2b_fail_idx", bus0.fail_idx, 2);
    tick();
    chk("or2b_fail_idx_held", bus0.fail_idx, 2);

    // XOR3 at SETTLE=0: one vector per cycle, done 9 cycles after start.
    bus1.expected = 8'b1001_0110;
    bus1.start    = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("xor3_busy_c%0d", c), bus1.busy, 1);
      chk($sformatf("xor3_done_c%0d", c), bus1.done, 0);
      chk($sformatf("xor3_dut_in_c%0d", c), bus1.dut_in, c - 1);
      tick();
    end
    chk("xor3_done_c9", bus1.done, 1);
    chk("xor3_truth", bus1.truth, 8'b1001_0110);
    chk("xor3_pass", bus1.pass, 1);
    chk("xor3_fail_idx", bus1.fail_idx, 0);

    // Abort during vector 1: truth[0] kept, vector-1 sample discarded.
    func_sel      = F_NAND;
    bus0.expected = 4'b0111;
    bus0.start    = 1'b1;
    tick();
    bus0.start = 1'b0;
    tick();
    tick();
    chk("abort_pre_dut_in", bus0.dut_in, 1);
    chk("abort_pre_truth", bus0.truth, 4'b0001);
    tick();
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    chk("abort_busy", bus0.busy, 0);
    chk("abort_done", bus0.done, 0);
    chk("abort_pass", bus0.pass, 0);
    chk("abort_truth", bus0.truth, 4'b0001);
    chk("abort_dut_in", bus0.dut_in, 0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus0.done) n_done++;
      tick();
    end
    chk("abort_no_done", n_done, 0);

    // start and abort together in IDLE: start wins, sweep runs normally.
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    chk("restart_busy", bus0.busy, 1);
    wait_done0(20, cyc);
    chk("restart_latency", cyc, 8);
    chk("restart_truth", bus0.truth, 4'b0111);
    chk("restart_pass", bus0.pass, 1);
    tick();

    // Reset mid-sweep in cycle 5.
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("midrst_truth_pre", bus0.truth, 4'b0011);
    chk("midrst_busy_pre", bus0.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_done", bus0.done, 0);
    chk("midrst_truth", bus0.truth, 0);
    chk("midrst_pass", bus0.pass, 0);
    chk("midrst_fail_idx", bus0.fail_idx, 0);
    chk("midrst_dut_in", bus0.dut_in, 0);

    // start pulses in WAIT and DONE are dropped.
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    tick();
    tick();
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    chk("ign_wait_dut_in", bus0.dut_in, 1);
    chk("ign_wait_busy", bus0.busy, 1);
    for (int c = 4; c < 9; c++) tick();
    chk("ign_done_c9", bus0.done, 1);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    chk("ign_done_busy", bus0.busy, 0);
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus0.done) n_done++;
      tick();
    end
    chk("ign_no_extra_done", n_done, 0);

    // start held for 20 edges: relaunch right after each done.
    func_sel      = F_AND;
    bus0.expected = 4'b1000;
    bus0.start    = 1'b1;
    tick();
    n_done      = 0;
    first_done  = -1;
    second_done = -1;
    for (int c = 1; c <= 24; c++) begin
      if (c == 20) bus0.start = 1'b0;
      if (bus0.done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (c == 10) chk("held_truth_c10", bus0.truth, 4'b1000);
      if (c == 11) chk("held_truth_cleared_c11", bus0.truth, 0);
      tick();
    end
    chk("held_done_count", n_done, 2);
    chk("held_first_done", first_done, 9);
    chk("held_second_done", second_done, 19);
    chk("held_pass", bus0.pass, 1);

    // Reset in IDLE clears the held verdict.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("idle_rst_pass", bus0.pass, 0);
    chk("idle_rst_truth", bus0.truth, 0);
    chk("idle_rst_truth3", bus1.truth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
